// File: rtl/button_event_gen_if.sv
// Event port between the button event generator and its consumer.
// The generator drives valid/btn/type and the consumer drives ready.
interface button_event_gen_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_btn;
    logic [1:0] evt_type;

    modport master (
        output evt_valid,
        output evt_btn,
        output evt_type,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_btn,
        input  evt_type,
        output evt_ready
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns five debounced button levels into PRESS / LONG / REPEAT / RELEASE events.
// Each button owns a one-entry pending slot. Slots are arbitrated round-robin
// into a single registered valid/ready event port.
module button_event_gen #(
    parameter int HOLD_CLOCKS   = 50_000_000,
    parameter int REPEAT_CLOCKS = 10_000_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                btnu_i,
    input  logic                btnd_i,
    input  logic                btnl_i,
    input  logic                btnr_i,
    input  logic                btnc_i,
    button_event_gen_if.master  evt,
    output logic [4:0]          ovf_o
);

    localparam int N          = 5;
    localparam int MAX_CLOCKS = (HOLD_CLOCKS > REPEAT_CLOCKS) ? HOLD_CLOCKS : REPEAT_CLOCKS;
    localparam int CW         = $clog2(MAX_CLOCKS + 1);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CLOCKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CLOCKS - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEATING} state_t;
    typedef enum logic [1:0] {EVT_PRESS, EVT_LONG, EVT_REPEAT, EVT_RELEASE} evt_t;

    logic [N-1:0]  btn;
    logic [N-1:0]  q;
    logic [N-1:0]  rise;
    logic [N-1:0]  fall;
    state_t        state     [N];
    state_t        state_nxt [N];
    logic [CW-1:0] cnt       [N];
    logic [CW-1:0] cnt_nxt   [N];
    logic [N-1:0]  gen;
    evt_t          gen_type  [N];
    logic [N-1:0]  slot_valid;
    evt_t          slot_type [N];
    logic [2:0]    ptr;
    logic          load;
    logic          grant_found;
    logic [2:0]    grant_idx;
    logic [N-1:0]  drain;

    // Index u=0, d=1, l=2, r=3, c=4.
    assign btn  = {btnc_i, btnr_i, btnl_i, btnd_i, btnu_i};
    assign rise = btn & ~q;
    assign fall = ~btn & q;

    // Advance a round-robin index with wrap-around past the last button.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= N) s = s - N;
        return 3'(s);
    endfunction

    // Per-button state register, hold counter and previous level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= '0;
            for (int i = 0; i < N; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            q <= btn;
            for (int i = 0; i < N; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Next-state and counter logic; a release always wins over a timed event.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            // NOTE: defaults first so no path through this block infers a latch.
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            if (rise[i]) begin
                state_nxt[i] = HELD;
                cnt_nxt[i]   = '0;
            end else if (fall[i]) begin
                state_nxt[i] = IDLE;
                cnt_nxt[i]   = '0;
            end else if (btn[i] && state[i] == HELD) begin
                if (cnt[i] == HOLD_LAST) begin
                    state_nxt[i] = REPEATING;
                    cnt_nxt[i]   = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end else if (btn[i] && state[i] == REPEATING) begin
                if (cnt[i] == REPEAT_LAST) cnt_nxt[i] = '0;
                else                       cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // Event generation from edges and counter thresholds.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            gen[i]      = 1'b0;
            gen_type[i] = EVT_PRESS;
            if (rise[i]) begin
                gen[i]      = 1'b1;
                gen_type[i] = EVT_PRESS;
            end else if (fall[i]) begin
                gen[i]      = 1'b1;
                gen_type[i] = EVT_RELEASE;
            end else if (btn[i] && state[i] == HELD && cnt[i] == HOLD_LAST) begin
                gen[i]      = 1'b1;
                gen_type[i] = EVT_LONG;
            end else if (btn[i] && state[i] == REPEATING && cnt[i] == REPEAT_LAST) begin
                gen[i]      = 1'b1;
                gen_type[i] = EVT_REPEAT;
            end
        end
    end

    // Round-robin pick of the first pending slot at or after the pointer.
    always_comb begin
        load        = !evt.evt_valid || evt.evt_ready;
        grant_found = 1'b0;
        grant_idx   = '0;
        drain       = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_found && slot_valid[rr_index(ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(ptr, k);
            end
        end
        if (load && grant_found) drain[grant_idx] = 1'b1;
    end

    // Pending slots: a slot drained on this edge may accept a new event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= '0;
            ovf_o      <= '0;
            // NOTE: slot payloads are reset as well so nothing stale is ever observable.
            for (int i = 0; i < N; i++) slot_type[i] <= EVT_PRESS;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gen[i]) begin
                    if (slot_valid[i] && !drain[i]) begin
                        ovf_o[i] <= 1'b1;
                    end else begin
                        slot_valid[i] <= 1'b1;
                        slot_type[i]  <= gen_type[i];
                    end
                end else if (drain[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer; stable while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt.evt_valid <= 1'b0;
            evt.evt_btn   <= '0;
            evt.evt_type  <= '0;
            ptr           <= '0;
        end else if (load) begin
            if (grant_found) begin
                evt.evt_valid <= 1'b1;
                evt.evt_btn   <= grant_idx;
                evt.evt_type  <= slot_type[grant_idx];
                ptr           <= rr_index(grant_idx, 1);
            end else begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: directed scenarios with literal
// expectations, then random button/ready/reset traffic against a reference model.
module tb_button_event_gen;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic       ready;
    logic [4:0] ovf;

    button_event_gen_if evt ();
    assign evt.evt_ready = ready;

    button_event_gen #(
        .HOLD_CLOCKS   (HOLD),
        .REPEAT_CLOCKS (REP)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .btnu_i (btn[0]),
        .btnd_i (btn[1]),
        .btnl_i (btn[2]),
        .btnr_i (btn[3]),
        .btnc_i (btn[4]),
        .evt    (evt),
        .ovf_o  (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int btn;
        int typ;
    } ev_t;
    ev_t log_q[$];

    // Reference model: cycles since the rising edge decide LONG/REPEAT.
    bit         model_ok = 1'b0;
    logic [4:0] m_q;
    int         m_k      [5];
    bit         m_slot_v [5];
    int         m_slot_t [5];
    bit         m_valid;
    int         m_btn;
    int         m_type;
    int         m_ptr;
    logic [4:0] m_ovf;
    bit         m_gen    [5];
    int         m_gen_t  [5];
    int         m_gi;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_ev(input string name, input int idx, input int c, input int b, input int t);
        if (idx >= log_q.size()) begin
            check({name, "_present"}, log_q.size(), idx + 1);
        end else begin
            check({name, "_cycle"}, log_q[idx].cyc, c);
            check({name, "_btn"},   log_q[idx].btn, b);
            check({name, "_type"},  log_q[idx].typ, t);
        end
    endtask

    // Inputs change 1 ns after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Falling edge: log accepted events, compare against the model, then
    // advance the model with the inputs the next rising edge will sample.
    always @(negedge clk) begin
        if (!rst && evt.evt_valid === 1'b1 && ready)
            log_q.push_back('{cyc, int'(evt.evt_btn), int'(evt.evt_type)});

        if (model_ok) begin
            check("evt_valid", int'(evt.evt_valid), int'(m_valid));
            if (m_valid) begin
                check("evt_btn",  int'(evt.evt_btn),  m_btn);
                check("evt_type", int'(evt.evt_type), m_type);
            end
            check("ovf", int'(ovf), int'(m_ovf));
        end

        if (rst) begin
            m_q      = '0;
            m_valid  = 1'b0;
            m_btn    = 0;
            m_type   = 0;
            m_ptr    = 0;
            m_ovf    = '0;
            for (int i = 0; i < 5; i++) begin
                m_k[i]      = 0;
                m_slot_v[i] = 1'b0;
                m_slot_t[i] = 0;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int i = 0; i < 5; i++) begin
                m_gen[i]   = 1'b0;
                m_gen_t[i] = 0;
                if (btn[i] && !m_q[i]) begin
                    m_gen[i] = 1'b1;
                    m_gen_t[i] = 0;
                    m_k[i] = 1;
                end else if (!btn[i] && m_q[i]) begin
                    m_gen[i] = 1'b1;
                    m_gen_t[i] = 3;
                end else if (btn[i]) begin
                    if (m_k[i] == HOLD) begin
                        m_gen[i] = 1'b1;
                        m_gen_t[i] = 1;
                    end else if (m_k[i] > HOLD && (m_k[i] - HOLD) % REP == 0) begin
                        m_gen[i] = 1'b1;
                        m_gen_t[i] = 2;
                    end
                    m_k[i]++;
                end
            end
            m_q = btn;

            if (!m_valid || ready) begin
                m_gi = -1;
                for (int k = 0; k < 5; k++)
                    if (m_gi < 0 && m_slot_v[(m_ptr + k) % 5]) m_gi = (m_ptr + k) % 5;
                if (m_gi >= 0) begin
                    m_valid  = 1'b1;
                    m_btn    = m_gi;
                    m_type   = m_slot_t[m_gi];
                    m_slot_v[m_gi] = 1'b0;
                    m_ptr    = (m_gi + 1) % 5;
                end else begin
                    m_valid = 1'b0;
                end
            end

            for (int i = 0; i < 5; i++) begin
                if (m_gen[i]) begin
                    if (m_slot_v[i]) m_ovf[i] = 1'b1;
                    else begin
                        m_slot_v[i] = 1'b1;
                        m_slot_t[i] = m_gen_t[i];
                    end
                end
            end
        end
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int rc;

        rst   = 1'b1;
        btn   = '0;
        ready = 1'b1;
        step(2);
        check("reset_valid", int'(evt.evt_valid), 0);
        check("reset_btn",   int'(evt.evt_btn),   0);
        check("reset_type",  int'(evt.evt_type),  0);
        check("reset_ovf",   int'(ovf),           0);
        rst = 1'b0;
        step(2);

        // Short tap on btnc.
        log_q.delete();
        c = cyc;
        btn = 5'b10000;
        step(3);
        btn = '0;
        step(10);
        check("tap_count", log_q.size(), 2);
        check_ev("tap_press", 0, c + 2, 4, 0);
        check_ev("tap_rel",   1, c + 5, 4, 3);
        check("tap_ovf", int'(ovf), 0);

        // Long hold on btnu for 20 cycles.
        log_q.delete();
        c = cyc;
        btn = 5'b00001;
        step(20);
        btn = '0;
        step(10);
        check("long_count", log_q.size(), 5);
        check_ev("long_press", 0, c + 2,  0, 0);
        check_ev("long_long",  1, c + 10, 0, 1);
        check_ev("long_rep1",  2, c + 14, 0, 2);
        check_ev("long_rep2",  3, c + 18, 0, 2);
        check_ev("long_rel",   4, c + 22, 0, 3);

        // Simultaneous press of all buttons from a fresh pointer.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        log_q.delete();
        c = cyc;
        btn = 5'b11111;
        step(6);
        btn = 5'b11100;
        step(1);
        btn = '0;
        step(12);
        check("simul_count", log_q.size(), 10);
        for (int i = 0; i < 5; i++) check_ev("simul_press", i, c + 2 + i, i, 0);
        for (int i = 0; i < 5; i++) check_ev("simul_rel", 5 + i, c + 8 + i, i, 3);

        // Backpressure: btnl tapped twice while the consumer stalls.
        log_q.delete();
        ready = 1'b0;
        c = cyc;
        btn = 5'b00100;
        step(2);
        btn = '0;
        step(2);
        btn = 5'b00100;
        step(2);
        btn = '0;
        step(3);
        check("bp_valid", int'(evt.evt_valid), 1);
        check("bp_btn",   int'(evt.evt_btn),   2);
        check("bp_type",  int'(evt.evt_type),  0);
        check("bp_ovf",   int'(ovf),           5'b00100);
        check("bp_accepted", log_q.size(), 0);
        ready = 1'b1;
        step(5);
        check("bp_count", log_q.size(), 2);
        check_ev("bp_press", 0, c + 9,  2, 0);
        check_ev("bp_rel",   1, c + 10, 2, 3);
        check("bp_idle", int'(evt.evt_valid), 0);

        // One-cycle btnr pulse: slot drained on the edge its RELEASE is written.
        log_q.delete();
        c = cyc;
        btn = 5'b01000;
        step(1);
        btn = '0;
        step(6);
        check("dw_count", log_q.size(), 2);
        check_ev("dw_press", 0, c + 2, 3, 0);
        check_ev("dw_rel",   1, c + 3, 3, 3);
        check("dw_ovf", int'(ovf), 5'b00100);

        // Reset while btnr is held and its PRESS is presented.
        ready = 1'b0;
        btn = 5'b01000;
        step(3);
        check("rh_pre_valid", int'(evt.evt_valid), 1);
        check("rh_pre_btn",   int'(evt.evt_btn),   3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        rc = cyc;
        check("rh_valid", int'(evt.evt_valid), 0);
        check("rh_btn",   int'(evt.evt_btn),   0);
        check("rh_type",  int'(evt.evt_type),  0);
        check("rh_ovf",   int'(ovf),           0);
        ready = 1'b1;
        log_q.delete();
        step(3);
        check_ev("rh_press", 0, rc + 2, 3, 0);
        btn = '0;
        step(6);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst   = 1'b0;
        btn   = '0;
        ready = 1'b1;
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
